// File: rtl/srl_chain_delay.sv
// srl_chain_delay -- per-channel addressable serial delay line.
//
// Each of WIDTH channels is a DEPTH-bit shift register, built as STAGES
// cascaded 32-bit segments (segment k bit 31 feeds segment k+1 bit 0).
// A shared tap address A selects one bit of every channel onto Q. A fill
// counter tracks how many positions have received data since the last
// reset, so that consumers can qualify Q with VALID.
//
// Parameters:
//   WIDTH  - number of independent channels (1..32)
//   STAGES - number of 32-bit segments per channel (1, 2, 4 or 8)
//
// Ports:
//   CLK    in   1      sole clock, rising edge
//   RST    in   1      synchronous active-high reset (clears fill count only)
//   CE     in   1      shift enable
//   D      in   WIDTH  serial data in, one bit per channel
//   A      in   AW     tap address shared by all channels
//   Q      out  WIDTH  per-channel bit at address A
//   Q_LAST out  WIDTH  per-channel bit DEPTH-1
//   VALID  out  1      tap at A holds data shifted in since last reset
//   FULL   out  1      all DEPTH positions written since last reset
//
// Build option:
//   SRL_CHAIN_OREG_EN - when defined, Q, Q_LAST and VALID are registered
//   (one extra cycle of latency, cleared by RST). FULL is never registered.

module srl_chain_delay #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 4,
  localparam int DEPTH = 32 * STAGES,
  localparam int AW    = 5 + $clog2(STAGES)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    A,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_LAST,
  output logic             VALID,
  output logic             FULL
);

  // Segment-select width; a single-segment chain still needs a 1-bit index.
  localparam int SW = (STAGES > 1) ? (AW - 5) : 1;
  localparam logic [AW:0] FILL_MAX = (AW + 1)'(DEPTH);

  // Storage powers up as zero and is deliberately never touched by RST.
  logic [WIDTH-1:0][STAGES-1:0][31:0] r_seg = '0;
  logic [AW:0]                        r_fill;

  logic [SW-1:0]    w_seg_idx;
  logic [WIDTH-1:0] w_tap;
  logic [WIDTH-1:0] w_last;
  logic             w_valid;
  logic             w_full;

  // Shift every channel by one position on each enabled edge.
  always_ff @(posedge CLK) begin
    if (CE) begin
      for (int ch = 0; ch < WIDTH; ch++) begin
        r_seg[ch][0] <= {r_seg[ch][0][30:0], D[ch]};
        for (int k = 1; k < STAGES; k++) begin
          r_seg[ch][k] <= {r_seg[ch][k][30:0], r_seg[ch][k-1][31]};
        end
      end
    end
  end

  // Fill counter: reset wins over CE, saturates at DEPTH.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fill <= '0;
    end else if (CE && (r_fill != FILL_MAX)) begin
      r_fill <= r_fill + {{AW{1'b0}}, 1'b1};
    end
  end

  // Upper address bits pick the segment, low five pick the bit within it.
  generate
    if (STAGES > 1) begin : g_multi_seg
      assign w_seg_idx = A[AW-1:5];
    end else begin : g_single_seg
      assign w_seg_idx = 1'b0;
    end
  endgenerate

  // Combinational tap and cascade-end selection per channel.
  always_comb begin
    w_tap  = '0;
    w_last = '0;
    for (int ch = 0; ch < WIDTH; ch++) begin
      w_tap[ch]  = r_seg[ch][w_seg_idx][A[4:0]];
      w_last[ch] = r_seg[ch][STAGES-1][31];
    end
  end

  // A tap is valid once more bits have entered than its address.
  assign w_valid = (r_fill > {1'b0, A});
  assign w_full  = (r_fill == FILL_MAX);

`ifdef SRL_CHAIN_OREG_EN
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_q_last;
  logic             r_valid;

  // Optional output stage: one cycle of latency, cleared on reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q      <= '0;
      r_q_last <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_q      <= w_tap;
      r_q_last <= w_last;
      r_valid  <= w_valid;
    end
  end

  assign Q      = r_q;
  assign Q_LAST = r_q_last;
  assign VALID  = r_valid;
`else
  assign Q      = w_tap;
  assign Q_LAST = w_last;
  assign VALID  = w_valid;
`endif

  assign FULL = w_full;

endmodule

// File: tb/tb_srl_chain_delay.sv
// Self-checking bench for srl_chain_delay (WIDTH=2, STAGES=4, default build).
module tb_srl_chain_delay;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CE;
  logic [1:0] D;
  logic [6:0] A;
  logic [1:0] Q;
  logic [1:0] Q_LAST;
  logic       VALID;
  logic       FULL;

  int n_pass  = 0;
  int n_total = 0;

  srl_chain_delay #(.WIDTH(2), .STAGES(4)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .D(D), .A(A),
    .Q(Q), .Q_LAST(Q_LAST), .VALID(VALID), .FULL(FULL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       ce;
    logic [1:0] d;
    logic [6:0] a;
    logic [1:0] q;
    logic [1:0] ql;
    logic       v;
    logic       f;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One rising edge, then settle away from it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Push zeros through the whole chain.
  task automatic flush();
    RST = 1'b0; CE = 1'b1; D = 2'b00;
    repeat (130) tick();
  endtask

  initial begin
    RST = 1'b0; CE = 1'b0; D = 2'b00; A = 7'd5;

    // Impulse at A=5, then CE hold and A changes (rst,ce,d,a,q,ql,v,f).
    tbl[0]  = '{1'b1, 1'b1, 2'b00, 7'd5, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 2'b01, 7'd5, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 2'b00, 7'd5, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 2'b00, 7'd5, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 2'b00, 7'd5, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 2'b00, 7'd5, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 2'b00, 7'd5, 2'b01, 2'b00, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 2'b00, 7'd5, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 2'b11, 7'd6, 2'b01, 2'b00, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 2'b11, 7'd7, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 2'b00, 7'd7, 2'b01, 2'b00, 1'b1, 1'b0};

    for (int i = 0; i < 11; i++) begin
      RST = tbl[i].rst; CE = tbl[i].ce; D = tbl[i].d; A = tbl[i].a;
      tick();
      chk($sformatf("tbl%0d_q", i),  {6'd0, Q},      {6'd0, tbl[i].q});
      chk($sformatf("tbl%0d_ql", i), {6'd0, Q_LAST}, {6'd0, tbl[i].ql});
      chk($sformatf("tbl%0d_v", i),  {7'd0, VALID},  {7'd0, tbl[i].v});
      chk($sformatf("tbl%0d_f", i),  {7'd0, FULL},   {7'd0, tbl[i].f});
    end

    // Full-length impulse: segment boundary at 31/32, cascade end at 127.
    flush();
    RST = 1'b1; tick();
    chk("s2_rst_v", {7'd0, VALID}, 8'd0);
    chk("s2_rst_f", {7'd0, FULL},  8'd0);
    RST = 1'b0; D = 2'b11; tick();
    D = 2'b00;
    for (int n = 2; n <= 140; n++) begin
      tick();
      if (n == 31) begin
        A = 7'd31; #1;
        chk("s2_a31_e31", {6'd0, Q}, 8'd0);
      end
      if (n == 32) begin
        A = 7'd31; #1;
        chk("s2_a31_e32", {6'd0, Q}, 8'd3);
        A = 7'd32; #1;
        chk("s2_a32_e32", {6'd0, Q}, 8'd0);
        chk("s2_a32_e32_v", {7'd0, VALID}, 8'd0);
      end
      if (n == 33) begin
        A = 7'd32; #1;
        chk("s2_a32_e33", {6'd0, Q}, 8'd3);
        chk("s2_a32_e33_v", {7'd0, VALID}, 8'd1);
        A = 7'd31; #1;
        chk("s2_a31_e33", {6'd0, Q}, 8'd0);
      end
      if (n == 127) begin
        A = 7'd127; #1;
        chk("s2_e127_q",  {6'd0, Q},      8'd0);
        chk("s2_e127_ql", {6'd0, Q_LAST}, 8'd0);
        chk("s2_e127_v",  {7'd0, VALID},  8'd0);
        chk("s2_e127_f",  {7'd0, FULL},   8'd0);
      end
      if (n == 128) begin
        chk("s2_e128_q",  {6'd0, Q},      8'd3);
        chk("s2_e128_ql", {6'd0, Q_LAST}, 8'd3);
        chk("s2_e128_v",  {7'd0, VALID},  8'd1);
        chk("s2_e128_f",  {7'd0, FULL},   8'd1);
      end
      if (n == 129) begin
        chk("s2_e129_ql", {6'd0, Q_LAST}, 8'd0);
        chk("s2_e129_f",  {7'd0, FULL},   8'd1);
      end
      if (n == 140) chk("s2_e140_f", {7'd0, FULL}, 8'd1);
    end

    // CE toggling: only enabled edges shift and count.
    flush();
    RST = 1'b1; CE = 1'b1; D = 2'b00; tick();
    RST = 1'b0; A = 7'd3;
    for (int i = 0; i < 10; i++) begin
      int c;
      CE = (i % 2 == 0) ? 1'b1 : 1'b0;
      D  = (i == 0) ? 2'b11 : 2'b00;
      tick();
      c = i / 2 + 1;
      chk($sformatf("s3_clk%0d_q", i + 1), {6'd0, Q}, (c == 4) ? 8'd3 : 8'd0);
      chk($sformatf("s3_clk%0d_v", i + 1), {7'd0, VALID}, (c > 3) ? 8'd1 : 8'd0);
    end

    // Reset mid-fill: data keeps shifting, fill restarts from zero.
    flush();
    RST = 1'b1; tick();
    RST = 1'b0; D = 2'b01; tick();
    D = 2'b00;
    repeat (59) tick();
    A = 7'd59; #1;
    chk("s4_pre_q59", {6'd0, Q},     8'd1);
    chk("s4_pre_v59", {7'd0, VALID}, 8'd1);
    A = 7'd60; #1;
    chk("s4_pre_v60", {7'd0, VALID}, 8'd0);
    chk("s4_pre_f",   {7'd0, FULL},  8'd0);
    RST = 1'b1; tick();
    RST = 1'b0;
    chk("s4_rst_q60", {6'd0, Q},      8'd1);
    chk("s4_rst_v",   {7'd0, VALID},  8'd0);
    chk("s4_rst_f",   {7'd0, FULL},   8'd0);
    chk("s4_rst_ql",  {6'd0, Q_LAST}, 8'd0);
    for (int n = 1; n <= 67; n++) begin
      tick();
      if (n == 60) chk("s4_n60_v", {7'd0, VALID}, 8'd0);
      if (n == 61) begin
        chk("s4_n61_v", {7'd0, VALID}, 8'd1);
        chk("s4_n61_q", {6'd0, Q},     8'd0);
      end
      if (n == 66) chk("s4_n66_ql", {6'd0, Q_LAST}, 8'd0);
      if (n == 67) chk("s4_n67_ql", {6'd0, Q_LAST}, 8'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
